// File: rtl/width_adapter.sv
// -----------------------------------------------------------------------------
// width_adapter
//
// Splits one wide master (cache line) read or write into RATIO narrow bus
// beats, where RATIO = MASTER_DATA_WIDTH / SLAVE_DATA_WIDTH (a power of two).
// Read beats are reassembled into a full line that m_datain holds until the
// next read completes.
//
// Optional feature (compile-time macro):
//   WIDTH_ADAPTER_CWF_EN : critical word first. Reads start at beat m_first
//                          and wrap modulo RATIO. When the macro is undefined,
//                          m_first is ignored and reads start at beat 0. The
//                          assembled line is identical either way.
//
// Ports:
//   clk         : clock, all state changes on its rising edge
//   rst         : asynchronous active-high reset
//   m_address   : line address (master side)
//   m_dataout   : write line from the master
//   m_be        : per-word write enable, bit i covers word i
//   m_first     : critical word index for reads
//   m_rd, m_wr  : level requests, held until m_ready (m_rd wins if both)
//   m_datain    : last assembled read line
//   m_ready     : one-cycle completion pulse
//   s_address   : bus word address = zero-extended {line address, beat}
//   s_datain    : write word to the bus
//   s_dataout   : read word from the bus
//   s_rd, s_wr  : bus strobes, held until s_ready
//   s_ready     : bus beat completion
//   o_dbg_state : current FSM state (IDLE=0, RD_BEAT=1, WR_BEAT=2, DONE=3)
//
// Handshake: a bus beat completes on a rising edge where a strobe (s_rd or
// s_wr) and s_ready are both high. The strobe, s_address and s_datain stay
// stable until that edge. s_ready is ignored while no strobe is active.
// -----------------------------------------------------------------------------
module width_adapter #(
   parameter int MASTER_DATA_WIDTH = 64,
   parameter int SLAVE_DATA_WIDTH  = 16,
   parameter int MASTER_ADR_WIDTH  = 14,
   parameter int SLAVE_ADR_WIDTH   = 16,
   localparam int RATIO = MASTER_DATA_WIDTH / SLAVE_DATA_WIDTH,
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [MASTER_ADR_WIDTH-1:0]  m_address,
   input  logic [MASTER_DATA_WIDTH-1:0] m_dataout,
   input  logic [RATIO-1:0]             m_be,
   input  logic [IDX_W-1:0]             m_first,
   input  logic                         m_rd,
   input  logic                         m_wr,
   output logic [MASTER_DATA_WIDTH-1:0] m_datain,
   output logic                         m_ready,
   output logic [SLAVE_ADR_WIDTH-1:0]   s_address,
   output logic [SLAVE_DATA_WIDTH-1:0]  s_datain,
   input  logic [SLAVE_DATA_WIDTH-1:0]  s_dataout,
   output logic                         s_rd,
   output logic                         s_wr,
   input  logic                         s_ready,
   output logic [1:0]                   o_dbg_state
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_BEAT = 2'd1;
   localparam logic [1:0] WR_BEAT = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   logic [1:0]                   r_state;
   logic [IDX_W-1:0]             r_beat;   // word slot of the current beat
   logic [IDX_W-1:0]             r_cnt;    // read beats accepted so far
   logic [MASTER_ADR_WIDTH-1:0]  r_addr;
   logic [MASTER_DATA_WIDTH-1:0] r_wdata;
   logic [RATIO-1:0]             r_be;
   logic [MASTER_DATA_WIDTH-1:0] r_rbuf;   // partial line under assembly
   logic [MASTER_DATA_WIDTH-1:0] r_mdata;  // last completed read line

   logic [IDX_W-1:0]             w_start_beat;
   logic [IDX_W-1:0]             w_next_beat;
   logic                         w_beat_en;
   logic [MASTER_DATA_WIDTH-1:0] w_rbuf_next;
   logic [SLAVE_ADR_WIDTH-1:0]   w_saddr;
   logic                         w_unused_first;

`ifdef WIDTH_ADAPTER_CWF_EN
   assign w_start_beat   = (RATIO > 1) ? m_first : '0;
   assign w_unused_first = 1'b0;
`else
   assign w_start_beat   = '0;
   assign w_unused_first = ^m_first;
`endif

   // With RATIO=1 the single slot is always 0; otherwise the IDX_W-bit
   // increment wraps modulo RATIO on its own.
   assign w_next_beat = (RATIO > 1) ? (r_beat + 1'b1) : '0;
   assign w_beat_en   = r_be[r_beat];

   always_comb begin
      w_rbuf_next = r_rbuf;
      w_rbuf_next[int'(r_beat) * SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH] = s_dataout;
   end

   generate
      if (RATIO > 1) begin : g_addr_multi
         assign w_saddr = SLAVE_ADR_WIDTH'({r_addr, r_beat});
      end else begin : g_addr_single
         assign w_saddr = SLAVE_ADR_WIDTH'(r_addr);
      end
   endgenerate

   assign s_address   = w_saddr;
   assign s_rd        = (r_state == RD_BEAT);
   assign s_wr        = (r_state == WR_BEAT) && w_beat_en;
   assign s_datain    = s_wr ? r_wdata[int'(r_beat) * SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH]
                             : '0;
   assign m_ready     = (r_state == DONE);
   assign m_datain    = r_mdata;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_beat  <= '0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_rbuf  <= '0;
         r_mdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (m_rd) begin
                  r_addr  <= m_address;
                  r_beat  <= w_start_beat;
                  r_cnt   <= '0;
                  r_state <= RD_BEAT;
               end else if (m_wr) begin
                  r_addr  <= m_address;
                  r_wdata <= m_dataout;
                  r_be    <= m_be;
                  r_beat  <= '0;
                  r_cnt   <= '0;
                  r_state <= WR_BEAT;
               end
            end
            RD_BEAT: begin
               if (s_ready) begin
                  r_rbuf <= w_rbuf_next;
                  r_beat <= w_next_beat;
                  r_cnt  <= r_cnt + 1'b1;
                  // Publish the line only once complete, merging the final word.
                  if (r_cnt == LAST_IDX) begin
                     r_mdata <= w_rbuf_next;
                     r_state <= DONE;
                  end
               end
            end
            WR_BEAT: begin
               // Masked-off words skip the bus but still cost one cycle.
               if (!w_beat_en || s_ready) begin
                  r_beat <= w_next_beat;
                  if (r_beat == LAST_IDX) begin
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_width_adapter.sv
module tb_width_adapter;

   localparam int MDW = 64;
   localparam int SDW = 16;
   localparam int MAW = 14;
   localparam int SAW = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [MAW-1:0] m_address;
   logic [MDW-1:0] m_dataout;
   logic [3:0]     m_be;
   logic [1:0]     m_first;
   logic           m_rd;
   logic           m_wr;
   logic [MDW-1:0] m_datain;
   logic           m_ready;
   logic [SAW-1:0] s_address;
   logic [SDW-1:0] s_datain;
   logic [SDW-1:0] s_dataout;
   logic           s_rd;
   logic           s_wr;
   logic           s_ready;
   logic [1:0]     o_dbg_state;

   width_adapter dut (
      .clk         (clk),
      .rst         (rst),
      .m_address   (m_address),
      .m_dataout   (m_dataout),
      .m_be        (m_be),
      .m_first     (m_first),
      .m_rd        (m_rd),
      .m_wr        (m_wr),
      .m_datain    (m_datain),
      .m_ready     (m_ready),
      .s_address   (s_address),
      .s_datain    (s_datain),
      .s_dataout   (s_dataout),
      .s_rd        (s_rd),
      .s_wr        (s_wr),
      .s_ready     (s_ready),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- bus slave model ----------------
   // Read data is the word address; dly=1 answers on the 4th strobe cycle.
   logic       dly;
   logic [1:0] wait_cnt;
   assign s_dataout = s_address;
   assign s_ready   = dly ? ((s_rd | s_wr) && (wait_cnt == 2'd3)) : 1'b1;

   always @(posedge clk or posedge rst) begin
      if (rst)                          wait_cnt <= 2'd0;
      else if ((s_rd | s_wr) && s_ready) wait_cnt <= 2'd0;
      else if (s_rd | s_wr)             wait_cnt <= wait_cnt + 2'd1;
      else                              wait_cnt <= 2'd0;
   end

   // ---------------- scoreboard ----------------
   // Entry format: {is_write, word address, data}
   logic [32:0] exp_q[$];
   logic [32:0] got_q[$];
   int          hold_err;
   logic        prev_wait;
   logic [15:0] prev_addr;
   logic [1:0]  prev_strb;
   int          n_tests = 0;
   int          n_fail  = 0;

   always @(negedge clk) begin
      if (rst) begin
         prev_wait = 1'b0;
      end else begin
         if ((s_rd | s_wr) && s_ready)
            got_q.push_back({s_wr, s_address, (s_wr ? s_datain : s_dataout)});
         if (prev_wait && ((s_address != prev_addr) || ({s_rd, s_wr} != prev_strb)))
            hold_err++;
         prev_wait = (s_rd | s_wr) && !s_ready;
         prev_addr = s_address;
         prev_strb = {s_rd, s_wr};
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic        rd;
      logic        wr;
      logic [13:0] addr;
      logic [1:0]  first;
      logic [63:0] dout;
      logic [3:0]  be;
      logic        dly;
      int          exp_lat;
      logic [63:0] exp_datain;
   } vec_t;

   localparam logic [63:0] LINE_12   = 64'h004B_004A_0049_0048;
   localparam logic [63:0] LINE_3FFF = 64'hFFFF_FFFE_FFFD_FFFC;

   vec_t vecs[9];

   // ---------------- driver ----------------
   task automatic build_expect(input vec_t v);
      logic [1:0]  b;
      logic [15:0] a;
      exp_q.delete();
      if (v.rd) begin
`ifdef WIDTH_ADAPTER_CWF_EN
         b = v.first;
`else
         b = 2'd0;
`endif
         for (int i = 0; i < 4; i++) begin
            a = {v.addr, b};
            exp_q.push_back({1'b0, a, a});
            b = b + 2'd1;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            b = 2'(i);
            a = {v.addr, b};
            if (v.be[i]) exp_q.push_back({1'b1, a, v.dout[i*16 +: 16]});
         end
      end
   endtask

   task automatic run_txn(input vec_t v, output int lat, output logic [63:0] line);
      int k;
      build_expect(v);
      @(negedge clk);
      got_q.delete();
      hold_err  = 0;
      m_rd      = v.rd;
      m_wr      = v.wr;
      m_address = v.addr;
      m_first   = v.first;
      m_dataout = v.dout;
      m_be      = v.be;
      dly       = v.dly;
      lat       = -1;
      line      = '0;
      @(posedge clk);  // request-sampling edge
      k = 0;
      while (k < 200) begin
         @(negedge clk);
         if (m_ready) begin
            lat  = k + 1;
            line = m_datain;
            m_rd = 1'b0;
            m_wr = 1'b0;
            break;
         end
         @(posedge clk);
         k++;
      end
      m_rd = 1'b0;
      m_wr = 1'b0;
      @(negedge clk);
      check("ready_one_cycle", {63'd0, m_ready}, 64'd0);
      check("idle_after_done", {62'd0, o_dbg_state}, 64'd0);
   endtask

   task automatic check_beats(input int id);
      check($sformatf("v%0d_nbeats", id), 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("v%0d_beat%0d", id, i), {31'd0, got_q[i]}, {31'd0, exp_q[i]});
      check($sformatf("v%0d_hold", id), 64'(hold_err), 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          lat;
      logic [63:0] line;
      int          pulses;
      int          pos0;
      int          pos1;

      m_address = '0; m_dataout = '0; m_be = '0; m_first = '0;
      m_rd = 1'b0; m_wr = 1'b0; dly = 1'b0;

      //          rd wr addr      first dout                    be       dly lat datain
      vecs[0] = '{1'b1, 1'b0, 14'h0012, 2'd0, 64'h0,                  4'b0000, 1'b0, 5,  LINE_12};
      vecs[1] = '{1'b1, 1'b0, 14'h0012, 2'd2, 64'h0,                  4'b0000, 1'b0, 5,  LINE_12};
      vecs[2] = '{1'b0, 1'b1, 14'h0012, 2'd0, 64'hDDDD_CCCC_BBBB_AAAA, 4'b0101, 1'b0, 5,  LINE_12};
      vecs[3] = '{1'b1, 1'b0, 14'h0012, 2'd0, 64'h0,                  4'b0000, 1'b1, 17, LINE_12};
      vecs[4] = '{1'b1, 1'b0, 14'h3FFF, 2'd3, 64'h0,                  4'b0000, 1'b0, 5,  LINE_3FFF};
      vecs[5] = '{1'b0, 1'b1, 14'h0001, 2'd0, 64'h1111_2222_3333_4444, 4'b1111, 1'b0, 5,  LINE_3FFF};
      vecs[6] = '{1'b0, 1'b1, 14'h0001, 2'd0, 64'h1111_2222_3333_4444, 4'b0000, 1'b0, 5,  LINE_3FFF};
      vecs[7] = '{1'b1, 1'b1, 14'h0012, 2'd0, 64'h5555_6666_7777_8888, 4'b1111, 1'b0, 5,  LINE_12};
      vecs[8] = '{1'b0, 1'b1, 14'h0002, 2'd0, 64'hAAAA_BBBB_CCCC_DDDD, 4'b1010, 1'b1, 11, LINE_12};

      // Reset state, with s_ready high the whole time (must be ignored in IDLE)
      #1 rst = 1'b1;
      #1;
      check("rst_m_ready",   {63'd0, m_ready}, 64'd0);
      check("rst_s_rd_wr",   {62'd0, s_rd, s_wr}, 64'd0);
      check("rst_s_address", 64'(s_address), 64'd0);
      check("rst_s_datain",  64'(s_datain), 64'd0);
      check("rst_m_datain",  m_datain, 64'd0);
      check("rst_state",     64'(o_dbg_state), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_ignores_s_ready", {60'd0, o_dbg_state, s_rd, s_wr}, 64'd0);

      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i], lat, line);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         check($sformatf("v%0d_m_datain", i), line, vecs[i].exp_datain);
         check_beats(i);
      end

      // Reset during beat 2 of a read: outputs clear at once, no m_ready
      @(negedge clk);
      m_rd = 1'b1; m_address = 14'h0012; m_first = 2'd0; dly = 1'b0;
      @(posedge clk);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("pre_rst_beat2_addr", 64'(s_address), 64'h004A);
      rst = 1'b1;
      #1;
      check("abort_s_rd_wr",   {62'd0, s_rd, s_wr}, 64'd0);
      check("abort_s_address", 64'(s_address), 64'd0);
      check("abort_s_datain",  64'(s_datain), 64'd0);
      check("abort_m_datain",  m_datain, 64'd0);
      check("abort_m_ready",   {63'd0, m_ready}, 64'd0);
      m_rd = 1'b0;
      pulses = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m_ready) pulses++;
      end
      check("abort_no_ready", 64'(pulses), 64'd0);
      run_txn(vecs[0], lat, line);
      check("post_rst_latency", 64'(lat), 64'd5);
      check("post_rst_m_datain", line, LINE_12);
      check_beats(100);

      // Request held through DONE starts a second transaction
      @(negedge clk);
      m_rd = 1'b1; m_address = 14'h0005; m_first = 2'd0; dly = 1'b0;
      pulses = 0; pos0 = -1; pos1 = -1;
      @(posedge clk);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (m_ready) begin
            if (pulses == 0) pos0 = k + 1;
            else if (pulses == 1) begin
               pos1 = k + 1;
               m_rd = 1'b0;
            end
            pulses++;
         end
         @(posedge clk);
      end
      m_rd = 1'b0;
      check("b2b_pulses", 64'(pulses), 64'd2);
      check("b2b_first",  64'(pos0), 64'd5);
      check("b2b_second", 64'(pos1), 64'd11);
      check("b2b_m_datain", m_datain, 64'h0017_0016_0015_0014);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
